rf_multiport: RTL

Parametrised multi-port register file for the core's decode/writeback stages, replacing the single-write, two-read file. It adds configurable read/write port counts, asynchronous reset to a defined value, a per-register busy scoreboard driven by an issue-side reservation port, and optional same-cycle write-to-read bypass. The hard-wired zero register is retained.

---
 rtl/rf_multiport.sv | 74 +++++++
 1 files changed

// File: rtl/rf_multiport.sv
// rf_multiport: parameterised multi-port register file with a hard-wired zero
// register, an issue-side busy scoreboard and asynchronous active-low reset.
// Optional feature macro: RF_BYPASS_EN forwards same-cycle writes to the read
// ports (data and readiness). Without the macro, reads come only from the
// stored state.
module rf_multiport #(
   parameter int unsigned    DW      = 8,
   parameter int unsigned    RFW     = 2,
   parameter int unsigned    NR      = 2,
   parameter int unsigned    NW      = 1,
   parameter logic [DW-1:0]  RST_VAL = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NW-1:0]         we,
   input  logic [NW*RFW-1:0]     wr_address,
   input  logic [NW*DW-1:0]      wr_data,
   input  logic                  rsv_en,
   input  logic [RFW-1:0]        rsv_address,
   input  logic [NR*RFW-1:0]     rr_address,
   output logic [NR*DW-1:0]      rr_data,
   output logic [NR-1:0]         rr_ready,
   output logic [(2**RFW)-1:0]   busy
);

   localparam int unsigned DEPTH = 2 ** RFW;

   logic [DW-1:0]    mem [DEPTH];
   logic [DEPTH-1:0] busy_q;

   // Storage and scoreboard update; later ports override earlier ones, and a
   // reservation overrides the busy clear caused by a write to the same register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= (i == 0) ? '0 : RST_VAL;
         end
         busy_q <= '0;
      end else begin
         for (int k = 0; k < int'(NW); k++) begin
            if (we[k] && (wr_address[k*RFW +: RFW] != '0)) begin
               mem[wr_address[k*RFW +: RFW]]    <= wr_data[k*DW +: DW];
               busy_q[wr_address[k*RFW +: RFW]] <= 1'b0;
            end
         end
         if (rsv_en && (rsv_address != '0)) begin
            busy_q[rsv_address] <= 1'b1;
         end
      end
   end

   // Combinational read ports with optional same-cycle write forwarding.
   always_comb begin
      rr_data  = '0;
      rr_ready = '0;
      for (int j = 0; j < int'(NR); j++) begin
         rr_data[j*DW +: DW] = mem[rr_address[j*RFW +: RFW]];
         rr_ready[j]         = ~busy_q[rr_address[j*RFW +: RFW]];
`ifdef RF_BYPASS_EN
         for (int k = 0; k < int'(NW); k++) begin
            if (we[k] && (wr_address[k*RFW +: RFW] != '0) &&
                (wr_address[k*RFW +: RFW] == rr_address[j*RFW +: RFW])) begin
               rr_data[j*DW +: DW] = wr_data[k*DW +: DW];
               rr_ready[j]         = ~(rsv_en && (rsv_address == rr_address[j*RFW +: RFW]));
            end
         end
`endif
      end
   end

   // Register 0 is never reserved, so its busy bit stays at its reset value.
   assign busy = busy_q;

endmodule
